// File: rtl/clock_group_reset_sequencer_if.sv
// Request channel for re-resetting one clock domain at runtime, plus the sequencer busy flag.
interface clock_group_reset_sequencer_if;
  logic       io_req_valid;
  logic       io_req_ready;
  logic [2:0] io_req_domain;
  logic       io_busy;

  modport master (
    output io_req_valid,
    output io_req_domain,
    input  io_req_ready,
    input  io_busy
  );

  modport slave (
    input  io_req_valid,
    input  io_req_domain,
    output io_req_ready,
    output io_busy
  );
endinterface

// File: rtl/clock_group_reset_sequencer.sv
// Per-domain clock-enable dividers and staggered, tick-aligned domain reset release.
// Runtime single-domain re-reset handshake is built only when CLOCK_GROUP_SEQ_REQ_EN is defined.
module clock_group_reset_sequencer #(
  parameter int N_DOMAINS = 7,
  parameter int DIV_W     = 4,
  parameter int HOLD      = 16,
  parameter int STAGGER   = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_DOMAINS*DIV_W-1:0]   io_divisor,
  clock_group_reset_sequencer_if.slave req_if,
  output logic [N_DOMAINS-1:0]         auto_out_clock_en,
  output logic [N_DOMAINS-1:0]         auto_out_reset
);

  localparam int CW = $clog2(HOLD + N_DOMAINS * STAGGER + 2) + 1;
  localparam logic [CW-1:0]        CYC_ONE   = CW'(1);
  localparam logic [CW-1:0]        HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0]        SLOT0     = CW'(HOLD);
  localparam logic [CW-1:0]        STAG_C    = CW'(STAGGER);
  localparam logic [2:0]           LAST_IDX  = 3'(N_DOMAINS - 1);
  localparam logic [N_DOMAINS-1:0] BIT0      = N_DOMAINS'(1);
  localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_DOM_HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [N_DOMAINS-1:0] rst_q, rst_d;
  logic [DIV_W-1:0]     cnt_q [N_DOMAINS];
  logic [DIV_W-1:0]     cnt_d [N_DOMAINS];
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [CW-1:0]        slot_q, slot_d;
  logic [2:0]           idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [N_DOMAINS-1:0] force_zero;
  logic [N_DOMAINS-1:0] clock_en;
  logic [N_DOMAINS-1:0] idx_mask;

`ifdef CLOCK_GROUP_SEQ_REQ_EN
  localparam int HW = $clog2(HOLD + 1) + 1;
  localparam logic [HW-1:0] HOLD_H   = HW'(HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [3:0]    NDOM4    = 4'(N_DOMAINS);

  logic [2:0]           dom_q, dom_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 req_fire;
  logic                 dom_ok;
  logic [N_DOMAINS-1:0] req_mask;
  logic [N_DOMAINS-1:0] dom_mask;

  assign req_fire = req_if.io_req_valid & ready_q;
  assign dom_ok   = ({1'b0, req_if.io_req_domain} < NDOM4);
  assign req_mask = BIT0 << req_if.io_req_domain;
  assign dom_mask = BIT0 << dom_q;
`else
  logic unused_req;
  assign unused_req = ^{req_if.io_req_valid, req_if.io_req_domain};
`endif

  // Each divider reloads only when it reaches zero, so a new divisor waits for the next tick.
  for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_div
    logic [DIV_W-1:0] div_field;
    assign div_field    = io_divisor[gi*DIV_W +: DIV_W];
    assign clock_en[gi] = (cnt_q[gi] == '0) & ~reset;
    assign cnt_d[gi]    = force_zero[gi]       ? '0 :
                          (cnt_q[gi] == '0)    ? div_field :
                                                 cnt_q[gi] - DIV_ONE;
  end

  assign idx_mask = BIT0 << idx_q;

  always_comb begin
    state_d    = state_q;
    rst_d      = rst_q;
    cyc_d      = cyc_q;
    slot_d     = slot_q;
    idx_d      = idx_q;
    force_zero = '0;
`ifdef CLOCK_GROUP_SEQ_REQ_EN
    dom_d      = dom_q;
    hold_d     = hold_q;
`endif
    case (state_q)
      ST_HOLD: begin
        cyc_d = cyc_q + CYC_ONE;
        if (cyc_q == HOLD_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (cyc_q != '1) cyc_d = cyc_q + CYC_ONE;
        // Only the next domain in index order may release, so a later early tick is ignored.
        if ((cyc_q >= slot_q) && |(clock_en & idx_mask)) begin
          rst_d  = rst_q & ~idx_mask;
          slot_d = slot_q + STAG_C;
          idx_d  = idx_q + 3'd1;
          if (idx_q == LAST_IDX) state_d = ST_RUN;
        end
      end
`ifdef CLOCK_GROUP_SEQ_REQ_EN
      ST_RUN: begin
        if (req_fire && dom_ok) begin
          rst_d      = rst_q | req_mask;
          force_zero = req_mask;
          dom_d      = req_if.io_req_domain;
          hold_d     = '0;
          state_d    = ST_DOM_HOLD;
        end
      end
      ST_DOM_HOLD: begin
        if (hold_q != HOLD_H) hold_d = hold_q + HOLD_ONE;
        if ((hold_q == HOLD_H) && |(clock_en & dom_mask)) begin
          rst_d   = rst_q & ~dom_mask;
          state_d = ST_RUN;
        end
      end
`endif
      default: ;
    endcase
    busy_d = (state_d != ST_RUN);
`ifdef CLOCK_GROUP_SEQ_REQ_EN
    ready_d = (state_d == ST_RUN);
`else
    ready_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_HOLD;
      rst_q   <= '1;
      cnt_q   <= '{default: '0};
      cyc_q   <= '0;
      slot_q  <= SLOT0;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
`ifdef CLOCK_GROUP_SEQ_REQ_EN
      dom_q   <= '0;
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef CLOCK_GROUP_SEQ_REQ_EN
      dom_q   <= dom_d;
      hold_q  <= hold_d;
`endif
    end
  end

  assign auto_out_clock_en = clock_en;
  assign auto_out_reset    = rst_q;
  assign req_if.io_busy      = busy_q;
  assign req_if.io_req_ready = ready_q;

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench for clock_group_reset_sequencer: release ordering, divider ticks, re-reset handshake.
`timescale 1ns/1ps
module tb_clock_group_reset_sequencer;
  localparam int N    = 7;
  localparam int DW   = 4;
  localparam int HMAX = 1024;
`ifdef CLOCK_GROUP_SEQ_REQ_EN
  localparam logic RDY_RUN = 1'b1;
`else
  localparam logic RDY_RUN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N*DW-1:0] io_divisor = '0;
  logic [N-1:0]  clock_en;
  logic [N-1:0]  rst_out;

  clock_group_reset_sequencer_if req_if ();

  always #5 clk = ~clk;

  clock_group_reset_sequencer #(
    .N_DOMAINS(N), .DIV_W(DW), .HOLD(16), .STAGGER(8)
  ) dut (
    .clock             (clk),
    .reset             (reset),
    .io_divisor        (io_divisor),
    .req_if            (req_if.slave),
    .auto_out_clock_en (clock_en),
    .auto_out_reset    (rst_out)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tb_cyc   = 0;
  logic [N-1:0] rst_hist   [HMAX];
  logic [N-1:0] en_hist    [HMAX];
  logic         busy_hist  [HMAX];
  logic         ready_hist [HMAX];

  // Cycle k is the interval after the k-th rising edge following reset release.
  always @(negedge clk) begin
    if (reset) begin
      tb_cyc <= 0;
    end else begin
      if (tb_cyc < HMAX) begin
        rst_hist[tb_cyc]   <= rst_out;
        en_hist[tb_cyc]    <= clock_en;
        busy_hist[tb_cyc]  <= req_if.io_busy;
        ready_hist[tb_cyc] <= req_if.io_req_ready;
      end
      tb_cyc <= tb_cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int first_low(input int bitn);
    for (int c = 0; c < tb_cyc && c < HMAX; c++)
      if (rst_hist[c][bitn] === 1'b0) return c;
    return -1;
  endfunction

  function automatic int first_idle();
    for (int c = 0; c < tb_cyc && c < HMAX; c++)
      if (busy_hist[c] === 1'b0) return c;
    return -1;
  endfunction

  function automatic logic [31:0] tick_mask(input int bitn);
    logic [31:0] m;
    m = '0;
    for (int c = 0; c < 32; c++) m[c] = en_hist[c][bitn];
    return m;
  endfunction

  task automatic do_reset(input string tag);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_rst"},   32'(rst_out), 32'h7f);
    check_eq({tag, "_en"},    32'(clock_en), 32'h0);
    check_eq({tag, "_busy"},  32'(req_if.io_busy), 32'h1);
    check_eq({tag, "_ready"}, 32'(req_if.io_req_ready), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_to(input int n);
    int k;
    k = 0;
    while (tb_cyc <= n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (tb_cyc <= n) check_eq("run_timeout", 32'(tb_cyc), 32'(n + 1));
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_if.io_req_valid === 1'b1 && req_if.io_req_ready === 1'b1) begin
        acc = tb_cyc;
        break;
      end
    end
    if (acc < 0) check_eq("accept_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int bad;
    int s;
    int a, b, c, e;
    logic [N-1:0] acc_rst;
    logic acc_rdy;
    req_if.io_req_valid  = 1'b0;
    req_if.io_req_domain = 3'd0;

    // All divisors 0: release at 17 + 8*i, clock_en every cycle.
    io_divisor = '0;
    do_reset("init");
    run_to(70);
    check_eq("c0_rst",   32'(rst_hist[0]), 32'h7f);
    check_eq("c0_en",    32'(en_hist[0]), 32'h7f);
    check_eq("c0_busy",  32'(busy_hist[0]), 32'h1);
    check_eq("c0_ready", 32'(ready_hist[0]), 32'h0);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("a_fall%0d", i), 32'(first_low(i)), 32'(17 + 8 * i));
    check_eq("a_busy_fall", 32'(first_idle()), 32'd65);
    check_eq("a_ready_run", 32'(ready_hist[65]), 32'(RDY_RUN));
    bad = 0;
    for (int k = 0; k <= 70; k++) if (en_hist[k] !== 7'h7f) bad++;
    check_eq("a_en_all", 32'(bad), 32'd0);

    // Domain 0 divisor 4: period 5, release waits for tick at 20.
    io_divisor = 28'h0000004;
    do_reset("b");
    run_to(40);
    check_eq("b_ticks0", tick_mask(0), 32'h42108421);
    check_eq("b_fall0",  32'(first_low(0)), 32'd21);
    check_eq("b_fall1",  32'(first_low(1)), 32'd25);

    // Domain 1 divisor 6: period 7, release at 29, domain 2 follows at 33.
    io_divisor = 28'h0000060;
    do_reset("c");
    run_to(70);
    check_eq("c_ticks1",    tick_mask(1), 32'h10204081);
    check_eq("c_fall0",     32'(first_low(0)), 32'd17);
    check_eq("c_fall1",     32'(first_low(1)), 32'd29);
    check_eq("c_fall2",     32'(first_low(2)), 32'd33);
    check_eq("c_busy_fall", 32'(first_idle()), 32'd65);

    io_divisor = '0;
    do_reset("d");
    run_to(70);
`ifdef CLOCK_GROUP_SEQ_REQ_EN
    @(posedge clk);
    #1 req_if.io_req_valid = 1'b1;
    req_if.io_req_domain = 3'd3;
    wait_accept(a);
    @(posedge clk);
    #1 req_if.io_req_domain = 3'd5;
    wait_accept(b);
    @(posedge clk);
    #1 req_if.io_req_valid = 1'b0;
    run_to(b + 20);
    check_eq("d_second_acc", 32'(b), 32'(a + 18));
    check_eq("d_rst_a",      32'(rst_hist[a]), 32'h00);
    check_eq("d_rst_a1",     32'(rst_hist[a + 1]), 32'h08);
    check_eq("d_rst_a16",    32'(rst_hist[a + 16]), 32'h08);
    check_eq("d_rst_a18",    32'(rst_hist[a + 18]), 32'h00);
    check_eq("d_rdy_a1",     32'(ready_hist[a + 1]), 32'h0);
    check_eq("d_rdy_a17",    32'(ready_hist[a + 17]), 32'h0);
    check_eq("d_rdy_a18",    32'(ready_hist[a + 18]), 32'h1);
    check_eq("d_busy_a1",    32'(busy_hist[a + 1]), 32'h1);
    check_eq("d_rst_b1",     32'(rst_hist[b + 1]), 32'h20);

    // Out-of-range domain is accepted without effect.
    @(posedge clk);
    #1 req_if.io_req_valid = 1'b1;
    req_if.io_req_domain = 3'd7;
    wait_accept(c);
    @(posedge clk);
    #1 req_if.io_req_valid = 1'b0;
    run_to(c + 3);
    check_eq("e_rst_c1",  32'(rst_hist[c + 1]), 32'h00);
    check_eq("e_rdy_c1",  32'(ready_hist[c + 1]), 32'h1);
    check_eq("e_busy_c1", 32'(busy_hist[c + 1]), 32'h0);

    // Reset during DOM_HOLD aborts and restarts the whole sequence.
    @(posedge clk);
    #1 req_if.io_req_valid = 1'b1;
    req_if.io_req_domain = 3'd2;
    wait_accept(e);
    @(posedge clk);
    #1 req_if.io_req_valid = 1'b0;
    run_to(e + 5);
    check_eq("f_rst_e4",  32'(rst_hist[e + 4]), 32'h04);
    check_eq("f_busy_e4", 32'(busy_hist[e + 4]), 32'h1);
    do_reset("f_mid");
    run_to(70);
    check_eq("f_fall0",     32'(first_low(0)), 32'd17);
    check_eq("f_fall6",     32'(first_low(6)), 32'd65);
    check_eq("f_busy_fall", 32'(first_idle()), 32'd65);
`else
    // Without the request feature, valid in RUN is ignored.
    @(posedge clk);
    s = tb_cyc;
    #1 req_if.io_req_valid = 1'b1;
    req_if.io_req_domain = 3'd3;
    run_to(s + 25);
    req_if.io_req_valid = 1'b0;
    acc_rst = '0;
    acc_rdy = 1'b0;
    for (int k = s; k < s + 25; k++) begin
      acc_rst = acc_rst | rst_hist[k];
      acc_rdy = acc_rdy | ready_hist[k];
    end
    check_eq("g_rst_quiet", 32'(acc_rst), 32'h0);
    check_eq("g_rdy_zero",  32'(acc_rdy), 32'h0);
    check_eq("g_busy",      32'(busy_hist[s + 10]), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
